// File: rtl/ncpu32k_ibus_fetchq_pkg.sv
// Shared defaults for the instruction-bus fetch queue.
package ncpu32k_ibus_fetchq_pkg;

  localparam int NCPU_AW            = 32;
  localparam int NCPU_IW            = 32;
  localparam int NCPU_IBUS_FQ_DEPTH = 4;

  // Pointer width: one extra bit over the index so full and empty differ.
  function automatic int fq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ncpu32k_fetchq_ctr.sv
// Pointer, drop-counter and credit logic for the fetch queue.
module ncpu32k_fetchq_ctr
  import ncpu32k_ibus_fetchq_pkg::*;
#(
  parameter int DEPTH = NCPU_IBUS_FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_fire,
  input  logic                       rsp_valid,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH)-1:0]   alloc_idx,
  output logic [$clog2(DEPTH)-1:0]   fill_idx,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       occ_nz,
  output logic                       credit,
  output logic                       rsp_fill
);

  localparam int PW = fq_ptr_w(DEPTH);
  localparam int AI = $clog2(DEPTH);
  localparam logic [PW-1:0] ONE     = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   DEPTH_W = DEPTH[PW:0];

  logic [PW-1:0] alloc_p, fill_p, rd_p, drop_cnt;
  logic [PW-1:0] alloc_next, fill_next, rd_next, drop_next;
  logic [PW-1:0] occ, unfilled;
  logic [PW-1:0] cmd_inc, rsp_dec;
  logic [PW:0]   use_norm, use_flush;

  assign occ       = alloc_p - rd_p;
  assign unfilled  = alloc_p - fill_p;
  assign cmd_inc   = {{(PW-1){1'b0}}, cmd_fire};
  assign rsp_dec   = {{(PW-1){1'b0}}, rsp_valid};

  // During a flush the buffered entries vanish, so only pending drops and
  // still-unfilled requests consume credit.
  assign use_norm  = {1'b0, occ} + {1'b0, drop_cnt};
  assign use_flush = {1'b0, unfilled} + {1'b0, drop_cnt};
  assign credit    = flush ? (use_flush < DEPTH_W) : (use_norm < DEPTH_W);

  assign alloc_idx = alloc_p[AI-1:0];
  assign fill_idx  = fill_p[AI-1:0];
  assign rd_idx    = rd_p[AI-1:0];
  assign occ_nz    = (occ != '0);
  assign rsp_fill  = rsp_valid & ~flush & (drop_cnt == '0);

  // Next-state for pointers and drop counter; flush overrides fill and pop.
  always_comb begin
    alloc_next = alloc_p + cmd_inc;
    fill_next  = fill_p;
    rd_next    = rd_p;
    drop_next  = drop_cnt;
    if (flush) begin
      fill_next = alloc_p;
      rd_next   = alloc_p;
      drop_next = drop_cnt + unfilled - rsp_dec;
    end else begin
      if (rsp_valid) begin
        if (drop_cnt != '0) begin
          drop_next = drop_cnt - ONE;
        end else begin
          fill_next = fill_p + ONE;
        end
      end
      if (pop) begin
        rd_next = rd_p + ONE;
      end
    end
  end

  // State registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_p  <= '0;
      fill_p   <= '0;
      rd_p     <= '0;
      drop_cnt <= '0;
    end else begin
      alloc_p  <= alloc_next;
      fill_p   <= fill_next;
      rd_p     <= rd_next;
      drop_cnt <= drop_next;
    end
  end

`ifdef NCPU_ENABLE_ASSERT
  // A response with nothing to drop and nothing awaiting data is a memory protocol error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_valid && drop_cnt == '0 && unfilled == '0))
        else $error("fetchq: orphan memory response");
    end
  end
`endif

endmodule

// File: rtl/ncpu32k_ibus_fetchq.sv
// In-order instruction fetch queue between the IFU and instruction memory.
module ncpu32k_ibus_fetchq
  import ncpu32k_ibus_fetchq_pkg::*;
#(
  parameter int AW    = NCPU_AW,
  parameter int IW    = NCPU_IW,
  parameter int DEPTH = NCPU_IBUS_FQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ibus_cmd_valid,
  output logic          ibus_cmd_ready,
  input  logic [AW-1:0] ibus_cmd_addr,
  output logic          ibus_dout_valid,
  input  logic          ibus_dout_ready,
  output logic [IW-1:0] ibus_dout,
  output logic [AW-1:0] ibus_out_id,
  input  logic          specul_flush,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_rsp_valid,
  input  logic [IW-1:0] mem_rsp_data
);

  localparam int AI = $clog2(DEPTH);

  logic [AI-1:0]    alloc_idx, fill_idx, rd_idx;
  logic             occ_nz, credit, rsp_fill;
  logic             cmd_fire, pop;
  logic [DEPTH-1:0] alloc_sel, fill_sel;

  logic [AW-1:0]    addr_reg   [DEPTH];
  logic [IW-1:0]    data_reg   [DEPTH];
  logic [DEPTH-1:0] filled_reg;

  ncpu32k_fetchq_ctr #(
    .DEPTH (DEPTH)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .cmd_fire  (cmd_fire),
    .rsp_valid (mem_rsp_valid),
    .pop       (pop),
    .flush     (specul_flush),
    .alloc_idx (alloc_idx),
    .fill_idx  (fill_idx),
    .rd_idx    (rd_idx),
    .occ_nz    (occ_nz),
    .credit    (credit),
    .rsp_fill  (rsp_fill)
  );

  // Request side is purely combinational: the command goes straight to memory.
  assign ibus_cmd_ready  = mem_req_ready & credit;
  assign mem_req_valid   = ibus_cmd_valid & credit & ~rst;
  assign mem_req_addr    = ibus_cmd_addr;
  assign cmd_fire        = ibus_cmd_valid & ibus_cmd_ready;

  // Head is presented from registered storage; a flush hides it immediately.
  assign ibus_dout_valid = ~rst & ~specul_flush & occ_nz & filled_reg[rd_idx];
  assign ibus_dout       = data_reg[rd_idx];
  assign ibus_out_id     = addr_reg[rd_idx];
  assign pop             = ibus_dout_valid & ibus_dout_ready;

  // Per-entry write enables for allocation and response fill.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign alloc_sel[gi] = cmd_fire & (alloc_idx == AI'(gi));
      assign fill_sel[gi]  = rsp_fill & (fill_idx == AI'(gi));
    end
  endgenerate

  // Entry storage: allocation records the address, fill records the insn.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_reg[i]   <= '0;
        data_reg[i]   <= '0;
        filled_reg[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_sel[i]) begin
          addr_reg[i]   <= ibus_cmd_addr;
          filled_reg[i] <= 1'b0;
        end
        if (fill_sel[i]) begin
          data_reg[i]   <= mem_rsp_data;
          filled_reg[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ncpu32k_ibus_fetchq.sv
// Directed self-checking bench for the instruction fetch queue.
module tb_ncpu32k_ibus_fetchq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_cmd_valid;
  logic        ibus_cmd_ready;
  logic [31:0] ibus_cmd_addr;
  logic        ibus_dout_valid;
  logic        ibus_dout_ready;
  logic [31:0] ibus_dout;
  logic [31:0] ibus_out_id;
  logic        specul_flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ncpu32k_ibus_fetchq #(
    .AW    (32),
    .IW    (32),
    .DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ibus_cmd_valid  (ibus_cmd_valid),
    .ibus_cmd_ready  (ibus_cmd_ready),
    .ibus_cmd_addr   (ibus_cmd_addr),
    .ibus_dout_valid (ibus_dout_valid),
    .ibus_dout_ready (ibus_dout_ready),
    .ibus_dout       (ibus_dout),
    .ibus_out_id     (ibus_out_id),
    .specul_flush    (specul_flush),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data)
  );

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] occ_now();
    return 32'(dut.u_ctr.occ);
  endfunction

  function automatic logic [31:0] drop_now();
    return 32'(dut.u_ctr.drop_cnt);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ibus_cmd_valid = 1'b0;
    ibus_cmd_addr = '0;
    ibus_dout_ready = 1'b0;
    specul_flush = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    cyc();
    cyc();
    rst = 1'b0;
    settle();
    chk("rst_dout_valid", 32'(ibus_dout_valid), 32'd0);
    chk("rst_occ", occ_now(), 32'd0);
    chk("rst_drop", drop_now(), 32'd0);

    // Test 1: three fetches, response latency 3, in-order delivery.
    ibus_cmd_valid = 1'b1;
    ibus_cmd_addr = 32'h100;
    settle();
    chk("t1_cmd_ready", 32'(ibus_cmd_ready), 32'd1);
    chk("t1_req_valid", 32'(mem_req_valid), 32'd1);
    chk("t1_req_addr", mem_req_addr, 32'h100);
    cyc();
    ibus_cmd_addr = 32'h104;
    cyc();
    ibus_cmd_addr = 32'h108;
    cyc();
    ibus_cmd_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = insn_of(32'h100);
    settle();
    chk("t1_valid_pre", 32'(ibus_dout_valid), 32'd0);
    cyc();
    mem_rsp_data = insn_of(32'h104);
    ibus_dout_ready = 1'b1;
    settle();
    chk("t1_valid0", 32'(ibus_dout_valid), 32'd1);
    chk("t1_id0", ibus_out_id, 32'h100);
    chk("t1_dout0", ibus_dout, insn_of(32'h100));
    cyc();
    mem_rsp_data = insn_of(32'h108);
    settle();
    chk("t1_id1", ibus_out_id, 32'h104);
    chk("t1_dout1", ibus_dout, insn_of(32'h104));
    cyc();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t1_valid2", 32'(ibus_dout_valid), 32'd1);
    chk("t1_id2", ibus_out_id, 32'h108);
    chk("t1_dout2", ibus_dout, insn_of(32'h108));
    cyc();
    ibus_dout_ready = 1'b0;
    settle();
    chk("t1_empty_valid", 32'(ibus_dout_valid), 32'd0);
    chk("t1_empty_occ", occ_now(), 32'd0);

    // Test 2: five commands with no pops; only four fit.
    ibus_cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ibus_cmd_addr = 32'h300 + 32'(4 * i);
      settle();
      chk("t2_cmd_ready", 32'(ibus_cmd_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) cyc();
    end
    chk("t2_occ_full", occ_now(), 32'd4);
    for (int j = 0; j < 4; j++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = insn_of(32'h300 + 32'(4 * j));
      settle();
      chk("t2_full_ready", 32'(ibus_cmd_ready), 32'd0);
      cyc();
    end
    mem_rsp_valid = 1'b0;
    ibus_dout_ready = 1'b1;
    settle();
    chk("t2_head_valid", 32'(ibus_dout_valid), 32'd1);
    chk("t2_id0", ibus_out_id, 32'h300);
    chk("t2_ready_before_pop", 32'(ibus_cmd_ready), 32'd0);
    cyc();
    settle();
    chk("t2_ready_after_pop", 32'(ibus_cmd_ready), 32'd1);
    chk("t2_id1", ibus_out_id, 32'h304);
    cyc();
    ibus_cmd_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = insn_of(32'h310);
    settle();
    chk("t2_id2", ibus_out_id, 32'h308);
    cyc();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t2_id3", ibus_out_id, 32'h30c);
    cyc();
    settle();
    chk("t2_id4", ibus_out_id, 32'h310);
    chk("t2_dout4", ibus_dout, insn_of(32'h310));
    cyc();
    ibus_dout_ready = 1'b0;
    settle();
    chk("t2_empty_valid", 32'(ibus_dout_valid), 32'd0);

    // Test 3: flush with two outstanding fetches plus a new command.
    ibus_cmd_valid = 1'b1;
    ibus_cmd_addr = 32'h400;
    cyc();
    ibus_cmd_addr = 32'h404;
    cyc();
    ibus_cmd_addr = 32'h408;
    cyc();
    ibus_cmd_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = insn_of(32'h400);
    cyc();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t3_head_before_flush", 32'(ibus_dout_valid), 32'd1);
    specul_flush = 1'b1;
    ibus_cmd_valid = 1'b1;
    ibus_cmd_addr = 32'h200;
    settle();
    chk("t3_flush_ready", 32'(ibus_cmd_ready), 32'd1);
    chk("t3_flush_valid", 32'(ibus_dout_valid), 32'd0);
    cyc();
    specul_flush = 1'b0;
    ibus_cmd_valid = 1'b0;
    settle();
    chk("t3_drop2", drop_now(), 32'd2);
    chk("t3_occ1", occ_now(), 32'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = insn_of(32'h404);
    cyc();
    mem_rsp_data = insn_of(32'h408);
    settle();
    chk("t3_drop1", drop_now(), 32'd1);
    chk("t3_valid_d1", 32'(ibus_dout_valid), 32'd0);
    cyc();
    mem_rsp_data = insn_of(32'h200);
    settle();
    chk("t3_drop0", drop_now(), 32'd0);
    chk("t3_valid_d0", 32'(ibus_dout_valid), 32'd0);
    cyc();
    mem_rsp_valid = 1'b0;
    ibus_dout_ready = 1'b1;
    settle();
    chk("t3_valid_new", 32'(ibus_dout_valid), 32'd1);
    chk("t3_id_new", ibus_out_id, 32'h200);
    chk("t3_dout_new", ibus_dout, insn_of(32'h200));
    cyc();
    ibus_dout_ready = 1'b0;
    settle();
    chk("t3_empty_occ", occ_now(), 32'd0);

    // Test 4: flush coinciding with the only outstanding response.
    ibus_cmd_valid = 1'b1;
    ibus_cmd_addr = 32'h500;
    cyc();
    ibus_cmd_valid = 1'b0;
    specul_flush = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = insn_of(32'h500);
    settle();
    chk("t4_flush_valid", 32'(ibus_dout_valid), 32'd0);
    cyc();
    specul_flush = 1'b0;
    mem_rsp_valid = 1'b0;
    settle();
    chk("t4_drop", drop_now(), 32'd0);
    chk("t4_occ", occ_now(), 32'd0);
    chk("t4_valid", 32'(ibus_dout_valid), 32'd0);
    cyc();
    settle();
    chk("t4_valid_later", 32'(ibus_dout_valid), 32'd0);

    // Test 5: streaming at latency 1, one insn per cycle.
    ibus_dout_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ibus_cmd_valid = (c < 8);
      ibus_cmd_addr = 32'h600 + 32'(4 * c);
      mem_rsp_valid = (c >= 1 && c <= 8);
      mem_rsp_data = insn_of(32'h600 + 32'(4 * (c - 1)));
      settle();
      if (c < 8) chk("t5_cmd_ready", 32'(ibus_cmd_ready), 32'd1);
      chk("t5_valid", 32'(ibus_dout_valid), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) chk("t5_id", ibus_out_id, 32'h600 + 32'(4 * (c - 2)));
      cyc();
    end
    ibus_cmd_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    ibus_dout_ready = 1'b0;
    settle();
    chk("t5_empty_valid", 32'(ibus_dout_valid), 32'd0);
    chk("t5_empty_occ", occ_now(), 32'd0);

    // Test 6: reset while two entries are filled.
    ibus_cmd_valid = 1'b1;
    ibus_cmd_addr = 32'h700;
    cyc();
    ibus_cmd_addr = 32'h704;
    cyc();
    ibus_cmd_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = insn_of(32'h700);
    cyc();
    mem_rsp_data = insn_of(32'h704);
    cyc();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t6_valid_pre", 32'(ibus_dout_valid), 32'd1);
    chk("t6_occ_pre", occ_now(), 32'd2);
    rst = 1'b1;
    ibus_cmd_valid = 1'b1;
    ibus_cmd_addr = 32'h7fc;
    settle();
    chk("t6_rst_req_valid", 32'(mem_req_valid), 32'd0);
    cyc();
    rst = 1'b0;
    ibus_cmd_valid = 1'b0;
    settle();
    chk("t6_valid", 32'(ibus_dout_valid), 32'd0);
    chk("t6_occ", occ_now(), 32'd0);
    chk("t6_drop", drop_now(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
